// File: rtl/fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb
//
// Write arbiter for the synchronous FIFO. It shares the single FIFO write port
// among N_REQ requesters. A requester is granted only when the FIFO has room
// for a whole MAX_BURST burst, and it keeps the grant until its burst ends.
// The burst ends on a last word, on the beat limit, or when the requester
// drops its request.
//
// Configuration macro:
//   FIFO_WR_ARB_FIXED_PRIO_EN - defined: fixed priority (lowest index wins,
//                               no round-robin pointer). Undefined (default):
//                               round-robin starting at the pointer.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_n_i         asynchronous active-low reset
//   req_i           per-requester request / word-valid
//   data_i          requester k's word at [k*WIDTH +: WIDTH]
//   last_i          current word is the last of the burst
//   gnt_o           one-hot grant (registered)
//   ack_o           requester k's word is written this cycle
//   fifo_wr_en_o    FIFO write enable
//   fifo_wr_data_o  FIFO write data (0 outside a burst)
//   fifo_wr_full_i  FIFO full flag (write interlock)
//   fifo_wr_free_i  FIFO free-word count
//
// States:
//   state | meaning
//   IDLE  | no grant; arbitrate when the FIFO has room for a full burst
//   BURST | gnt_o[idx_q] held; one word per cycle until the burst ends
// ---------------------------------------------------------------------------
module fifo_wr_arb #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 64,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*WIDTH-1:0]   data_i,
    input  logic [N_REQ-1:0]         last_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [N_REQ-1:0]         ack_o,
    output logic                     fifo_wr_en_o,
    output logic [WIDTH-1:0]         fifo_wr_data_o,
    input  logic                     fifo_wr_full_i,
    input  logic [$clog2(DEPTH):0]   fifo_wr_free_i
);

    localparam int FW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam int PW = $clog2(N_REQ);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_d;
    logic [PW-1:0]    idx_q, idx_d;     // index of the granted requester
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    cand;
    logic [PW-1:0]    pick;
    logic             found;
    logic             room;
    logic             in_burst;
    logic             cur_req;
    logic             cur_last;
    logic             wr;
    logic             burst_end;
`ifndef FIFO_WR_ARB_FIXED_PRIO_EN
    logic [PW-1:0]    ptr_q, ptr_d;
`endif

    // First requesting index, scanning upward from the pointer with wrap.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
            cand = PW'(i);
`else
            cand = PW'((int'(ptr_q) + i) % N_REQ);
`endif
            if (!found && req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign room      = (fifo_wr_free_i >= FW'(MAX_BURST));
    assign in_burst  = (state_q == BURST);
    assign cur_req   = req_i[idx_q];
    assign cur_last  = last_i[idx_q];
    // Full is never expected while granted; it still blocks the write.
    assign wr        = in_burst & cur_req & ~fifo_wr_full_i;
    // A dropped request abandons the burst without writing.
    assign burst_end = in_burst &
                       (~cur_req | (wr & (cur_last | (cnt_q == CW'(MAX_BURST - 1)))));

    assign ack_o          = wr ? gnt_o : '0;
    assign fifo_wr_en_o   = wr;
    assign fifo_wr_data_o = in_burst ? data_i[int'(idx_q)*WIDTH +: WIDTH] : '0;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_o;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
`ifndef FIFO_WR_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found && room) begin
                    gnt_d[pick] = 1'b1;
                    idx_d       = pick;
                    cnt_d       = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                if (wr) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (burst_end) begin
                    gnt_d   = '0;
                    state_d = IDLE;
`ifndef FIFO_WR_ARB_FIXED_PRIO_EN
                    ptr_d   = (idx_q == PW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            gnt_o   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
`ifndef FIFO_WR_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_o   <= gnt_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
`ifndef FIFO_WR_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arb
//
// Bench for fifo_wr_arb. Requester models present bursts and advance on ack.
// Each scenario pushes the FIFO words it expects, in expected write order,
// onto a scoreboard queue. Every FIFO write pops the queue and is compared.
// Grant order, burst lengths and idle gaps are logged and checked per test.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arb;

    localparam int N_REQ     = 4;
    localparam int WIDTH     = 32;
    localparam int DEPTH     = 64;
    localparam int MAX_BURST = 8;
    localparam int FW        = $clog2(DEPTH) + 1;

    logic                   clk_i = 1'b0;
    logic                   rst_n_i;
    logic [N_REQ-1:0]       req_i;
    logic [N_REQ*WIDTH-1:0] data_i;
    logic [N_REQ-1:0]       last_i;
    logic [N_REQ-1:0]       gnt_o;
    logic [N_REQ-1:0]       ack_o;
    logic                   fifo_wr_en_o;
    logic [WIDTH-1:0]       fifo_wr_data_o;
    logic                   fifo_wr_full_i;
    logic [FW-1:0]          fifo_wr_free_i;

    fifo_wr_arb #(
        .N_REQ(N_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .req_i          (req_i),
        .data_i         (data_i),
        .last_i         (last_i),
        .gnt_o          (gnt_o),
        .ack_o          (ack_o),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .fifo_wr_full_i (fifo_wr_full_i),
        .fifo_wr_free_i (fifo_wr_free_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] sb[$];

    int rem[N_REQ];
    int seq[N_REQ];
    int blen[N_REQ];
    int bursts_left[N_REQ];
    int drop_after[N_REQ];
    int acks_in[N_REQ];
    bit use_last[N_REQ];

    logic [N_REQ-1:0] s_gnt, s_ack, prev_gnt;
    logic             s_wen;
    int               cur_acks, idle_cnt;
    logic [N_REQ-1:0] gnt_log[$];
    int               len_log[$];
    int               gap_log[$];

    function automatic logic [WIDTH-1:0] mk_word(input int k, input int s);
        logic [WIDTH-1:0] w;
        w = {8'(k), 24'(s)};
        return w;
    endfunction

    task automatic apply_inputs();
        for (int k = 0; k < N_REQ; k++) begin
            req_i[k]  = (rem[k] > 0);
            last_i[k] = use_last[k] && (rem[k] == 1);
            data_i[k*WIDTH +: WIDTH] = mk_word(k, seq[k]);
        end
    endtask

    task automatic start_burst(input int k, input int len, input int nb,
                               input bit lst, input int drop);
        blen[k]        = len;
        rem[k]         = len;
        bursts_left[k] = nb - 1;
        use_last[k]    = lst;
        drop_after[k]  = drop;
        acks_in[k]     = 0;
    endtask

    task automatic push_words(input int k, input int s0, input int n);
        for (int j = 0; j < n; j++) sb.push_back(mk_word(k, s0 + j));
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        len_log.delete();
        gap_log.delete();
    endtask

    // One clock cycle: sample at the falling edge, update models after rise.
    task automatic step();
        logic [WIDTH-1:0] exp_w;
        @(negedge clk_i);
        s_gnt = gnt_o;
        s_ack = ack_o;
        s_wen = fifo_wr_en_o;
        n_cmp++;
        if (!$onehot0(gnt_o)) begin
            n_err++;
            $display("FAIL gnt_onehot: got %b, required at most one bit", gnt_o);
        end
        if (fifo_wr_en_o) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got write of %h, required no write", fifo_wr_data_o);
            end else begin
                exp_w = sb.pop_front();
                if (fifo_wr_data_o !== exp_w) begin
                    n_err++;
                    $display("FAIL wr_data: got %h, required %h", fifo_wr_data_o, exp_w);
                end
            end
            n_cmp++;
            if (fifo_wr_full_i !== 1'b0) begin
                n_err++;
                $display("FAIL wr_while_full: got wr_en=1 with full=1, required wr_en=0");
            end
            n_cmp++;
            if (ack_o !== gnt_o) begin
                n_err++;
                $display("FAIL ack_grant: got ack %b, required %b", ack_o, gnt_o);
            end
        end else begin
            n_cmp++;
            if (ack_o !== '0) begin
                n_err++;
                $display("FAIL ack_no_write: got ack %b, required 0", ack_o);
            end
        end
        if (prev_gnt != '0 && s_gnt != prev_gnt) begin
            len_log.push_back(cur_acks);
            idle_cnt = 0;
        end
        if (s_gnt != '0 && s_gnt != prev_gnt) begin
            gnt_log.push_back(s_gnt);
            gap_log.push_back(idle_cnt);
            cur_acks = 0;
        end
        if (s_gnt == '0) idle_cnt++;
        else if (s_wen) cur_acks++;
        prev_gnt = s_gnt;

        @(posedge clk_i);
        #1;
        for (int k = 0; k < N_REQ; k++) begin
            if (s_ack[k]) begin
                seq[k]++;
                rem[k]--;
                acks_in[k]++;
                if (drop_after[k] > 0 && acks_in[k] == drop_after[k]) rem[k] = 0;
                if (rem[k] == 0 && bursts_left[k] > 0) begin
                    bursts_left[k]--;
                    rem[k]     = blen[k];
                    acks_in[k] = 0;
                end
            end
        end
        apply_inputs();
    endtask

    task automatic run_until_idle(input int max_cyc, input string name);
        int c;
        bit busy;
        c = 0;
        do begin
            step();
            c++;
            busy = (sb.size() != 0) || (s_gnt != '0);
            for (int k = 0; k < N_REQ; k++) if (rem[k] > 0) busy = 1'b1;
        end while (busy && c < max_cyc);
        n_cmp++;
        if (busy) begin
            n_err++;
            $display("FAIL %s_timeout: got busy after %0d cycles, required idle", name, c);
        end
    endtask

    task automatic do_reset();
        rst_n_i        = 1'b0;
        fifo_wr_full_i = 1'b0;
        fifo_wr_free_i = FW'(DEPTH);
        for (int k = 0; k < N_REQ; k++) begin
            rem[k] = 0; seq[k] = 0; blen[k] = 0; bursts_left[k] = 0;
            drop_after[k] = 0; acks_in[k] = 0; use_last[k] = 1'b0;
        end
        apply_inputs();
        sb.delete();
        clear_logs();
        prev_gnt = '0;
        idle_cnt = 0;
        cur_acks = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_i);
        n_cmp++;
        if (gnt_o !== '0) begin n_err++; $display("FAIL rst_gnt: got %b, required 0", gnt_o); end
        n_cmp++;
        if (ack_o !== '0) begin n_err++; $display("FAIL rst_ack: got %b, required 0", ack_o); end
        n_cmp++;
        if (fifo_wr_en_o !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %b, required 0", fifo_wr_en_o); end
        n_cmp++;
        if (fifo_wr_data_o !== '0) begin n_err++; $display("FAIL rst_wr_data: got %h, required 0", fifo_wr_data_o); end
    endtask

    task automatic test_single();
        logic [N_REQ-1:0] exp_first;
        do_reset();
        start_burst(0, 3, 1, 1'b1, 0);
        push_words(0, 0, 3);
        apply_inputs();
        step();
        n_cmp++;
        if (s_gnt !== 4'b0000) begin n_err++; $display("FAIL single_pre_gnt: got %b, required 0000", s_gnt); end
        for (int b = 0; b < 3; b++) begin
            step();
            n_cmp++;
            if (s_gnt !== 4'b0001 || s_ack !== 4'b0001) begin
                n_err++;
                $display("FAIL single_beat%0d: got gnt %b ack %b, required 0001/0001", b, s_gnt, s_ack);
            end
        end
        step();
        n_cmp++;
        if (s_gnt !== 4'b0000) begin n_err++; $display("FAIL single_idle: got %b, required 0000", s_gnt); end
        // pointer now 1: requesters 0 and 1 together
        clear_logs();
        start_burst(0, 1, 1, 1'b1, 0);
        start_burst(1, 1, 1, 1'b1, 0);
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
        exp_first = 4'b0001;
        push_words(0, 3, 1);
        push_words(1, 0, 1);
`else
        exp_first = 4'b0010;
        push_words(1, 0, 1);
        push_words(0, 3, 1);
`endif
        apply_inputs();
        run_until_idle(50, "single_ptr");
        n_cmp++;
        if (gnt_log.size() != 2 || gnt_log[0] !== exp_first) begin
            n_err++;
            $display("FAIL single_ptr_order: got %0d grants first %b, required 2 first %b",
                     gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : 4'b0, exp_first);
        end
    endtask

    task automatic test_all();
        logic [N_REQ-1:0] exp_g[5];
        do_reset();
        start_burst(0, 8, 2, 1'b0, 0);
        for (int k = 1; k < N_REQ; k++) start_burst(k, 8, 1, 1'b0, 0);
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0001; exp_g[2] = 4'b0010;
        exp_g[3] = 4'b0100; exp_g[4] = 4'b1000;
        push_words(0, 0, 16);
        push_words(1, 0, 8); push_words(2, 0, 8); push_words(3, 0, 8);
`else
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        push_words(0, 0, 8);
        push_words(1, 0, 8); push_words(2, 0, 8); push_words(3, 0, 8);
        push_words(0, 8, 8);
`endif
        apply_inputs();
        run_until_idle(200, "all");
        n_cmp++;
        if (gnt_log.size() != 5 || len_log.size() != 5) begin
            n_err++;
            $display("FAIL all_count: got %0d grants %0d ends, required 5/5", gnt_log.size(), len_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (gnt_log[i] !== exp_g[i]) begin
                    n_err++;
                    $display("FAIL all_order%0d: got %b, required %b", i, gnt_log[i], exp_g[i]);
                end
                n_cmp++;
                if (len_log[i] != MAX_BURST) begin
                    n_err++;
                    $display("FAIL all_len%0d: got %0d, required %0d", i, len_log[i], MAX_BURST);
                end
                if (i > 0) begin
                    n_cmp++;
                    if (gap_log[i] != 1) begin
                        n_err++;
                        $display("FAIL all_gap%0d: got %0d idle cycles, required 1", i, gap_log[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_free();
        do_reset();
        fifo_wr_free_i = FW'(7);
        start_burst(1, 1, 1, 1'b1, 0);
        push_words(1, 0, 1);
        apply_inputs();
        repeat (3) step();
        n_cmp++;
        if (s_gnt !== 4'b0000 || gnt_log.size() != 0) begin
            n_err++;
            $display("FAIL free7_no_gnt: got %b (%0d grants), required 0000", s_gnt, gnt_log.size());
        end
        fifo_wr_free_i = FW'(8);
        step();
        n_cmp++;
        if (s_gnt !== 4'b0000) begin n_err++; $display("FAIL free8_pre: got %b, required 0000", s_gnt); end
        step();
        n_cmp++;
        if (s_gnt !== 4'b0010) begin n_err++; $display("FAIL free8_gnt: got %b, required 0010", s_gnt); end
        run_until_idle(20, "free");
    endtask

    task automatic test_drop();
        logic [N_REQ-1:0] exp_first;
        do_reset();
        start_burst(2, 5, 1, 1'b0, 2);
        push_words(2, 0, 2);
        apply_inputs();
        repeat (4) step();
        n_cmp++;
        if (s_gnt !== 4'b0100 || s_wen !== 1'b0) begin
            n_err++;
            $display("FAIL drop_cycle: got gnt %b wr_en %b, required 0100/0", s_gnt, s_wen);
        end
        step();
        n_cmp++;
        if (s_gnt !== 4'b0000) begin n_err++; $display("FAIL drop_end: got %b, required 0000", s_gnt); end
        n_cmp++;
        if (len_log.size() != 1 || len_log[0] != 2) begin
            n_err++;
            $display("FAIL drop_len: got %0d ends first %0d, required 1 end of 2 words",
                     len_log.size(), (len_log.size() > 0) ? len_log[0] : -1);
        end
        // pointer now 3: requesters 0 and 3 together
        clear_logs();
        start_burst(0, 1, 1, 1'b1, 0);
        start_burst(3, 1, 1, 1'b1, 0);
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
        exp_first = 4'b0001;
        push_words(0, 0, 1);
        push_words(3, 0, 1);
`else
        exp_first = 4'b1000;
        push_words(3, 0, 1);
        push_words(0, 0, 1);
`endif
        apply_inputs();
        run_until_idle(50, "drop_ptr");
        n_cmp++;
        if (gnt_log.size() != 2 || gnt_log[0] !== exp_first) begin
            n_err++;
            $display("FAIL drop_ptr_order: got %0d grants first %b, required 2 first %b",
                     gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : 4'b0, exp_first);
        end
    endtask

    task automatic test_last8();
        int c;
        do_reset();
        start_burst(1, 8, 1, 1'b1, 0);
        push_words(1, 0, 8);
        apply_inputs();
        c = 0;
        while (seq[1] < 3 && c < 20) begin step(); c++; end
        fifo_wr_full_i = 1'b1;
        step();
        n_cmp++;
        if (s_wen !== 1'b0 || s_gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL full_stall: got wr_en %b gnt %b, required 0/0010", s_wen, s_gnt);
        end
        step();
        fifo_wr_full_i = 1'b0;
        run_until_idle(30, "last8");
        n_cmp++;
        if (gnt_log.size() != 1 || len_log.size() != 1 || len_log[0] != 8) begin
            n_err++;
            $display("FAIL last8_single: got %0d grants %0d ends, required 1 burst of 8 words",
                     gnt_log.size(), len_log.size());
        end
    endtask

    task automatic test_rst_mid();
        int c;
        do_reset();
        start_burst(1, 1, 1, 1'b1, 0);
        push_words(1, 0, 1);
        apply_inputs();
        run_until_idle(20, "rst_pre");
        start_burst(2, 8, 1, 1'b0, 0);
        push_words(2, 0, 4);
        apply_inputs();
        c = 0;
        while (s_gnt !== 4'b0100 && c < 10) begin step(); c++; end
        start_burst(1, 1, 1, 1'b1, 0);
        start_burst(3, 1, 1, 1'b1, 0);
        apply_inputs();
        c = 0;
        while (seq[2] < 4 && c < 20) begin step(); c++; end
        n_cmp++;
        if (seq[2] != 4) begin n_err++; $display("FAIL rst_beat4: got %0d acks, required 4", seq[2]); end
        #1;
        rst_n_i = 1'b0;
        #1;
        n_cmp++;
        if (gnt_o !== '0 || ack_o !== '0 || fifo_wr_en_o !== 1'b0 || fifo_wr_data_o !== '0) begin
            n_err++;
            $display("FAIL rst_async: got gnt %b ack %b wr_en %b data %h, required all 0",
                     gnt_o, ack_o, fifo_wr_en_o, fifo_wr_data_o);
        end
        rem[2] = 0;
        apply_inputs();
        step();
        rst_n_i = 1'b1;
        push_words(1, 1, 1);
        push_words(3, 0, 1);
        step();
        n_cmp++;
        if (s_gnt !== 4'b0000) begin n_err++; $display("FAIL rst_release_pre: got %b, required 0000", s_gnt); end
        step();
        n_cmp++;
        if (s_gnt !== 4'b0010) begin n_err++; $display("FAIL rst_release_gnt: got %b, required 0010", s_gnt); end
        run_until_idle(30, "rst_post");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_all();
        test_free();
        test_drop();
        test_last8();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
